// File: rtl/fetch_if.sv
// Bundle that connects the IF stage to the hazard unit, EX redirect, the instruction memory and ID.
// The master modport is the fetch stage. The slave modport is the surrounding pipeline.
interface fetch_if #(
  parameter int ADDR_W = 32
);
  logic              i_stall;
  logic              i_flush;
  logic              i_redirect;
  logic [ADDR_W-1:0] i_redirect_pc;
  logic [ADDR_W-1:0] o_imem_addr;
  logic [31:0]       i_imem_inst;
  logic [ADDR_W-1:0] o_id_pc;
  logic [ADDR_W-1:0] o_id_pc4;
  logic [31:0]       o_id_inst;
  logic              o_id_valid;
  logic              o_misalign;
  logic [31:0]       o_fetch_cnt;

  modport master (
    input  i_stall, i_flush, i_redirect, i_redirect_pc, i_imem_inst,
    output o_imem_addr, o_id_pc, o_id_pc4, o_id_inst, o_id_valid,
           o_misalign, o_fetch_cnt
  );

  modport slave (
    output i_stall, i_flush, i_redirect, i_redirect_pc, i_imem_inst,
    input  o_imem_addr, o_id_pc, o_id_pc4, o_id_inst, o_id_valid,
           o_misalign, o_fetch_cnt
  );
endinterface

// File: rtl/fetch_stage.sv
// RV32I IF stage: program counter, instruction-memory address, and the IF/ID register.
// It handles stall, flush and redirect, and keeps a debug count of loaded instructions.
module fetch_stage #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [31:0]       NOP_INST = 32'h0000_0013
) (
  input  logic   i_clk,
  input  logic   i_rst_n,
  fetch_if.master bus
);

  typedef enum logic {BOOT, RUN} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_plus4;
  logic              do_redirect;
  logic              do_bubble;
  logic              do_load;
  logic              do_advance;

  assign pc_plus4         = pc + ADDR_W'(4);
  assign bus.o_imem_addr  = pc;

  // NOTE: sequential state uses non-blocking assignments so that every
  // register samples pre-edge values regardless of process order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= BOOT;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      BOOT:    state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  // NOTE: every output is assigned a default first, so no path can leave an
  // output unassigned. This keeps the comb block from inferring latches.
  always_comb begin
    do_redirect = 1'b0;
    do_bubble   = 1'b0;
    do_load     = 1'b0;
    do_advance  = 1'b0;
    if (state == RUN) begin
      do_redirect = bus.i_redirect;
      do_bubble   = bus.i_redirect | bus.i_flush;
      do_load     = ~(bus.i_redirect | bus.i_flush) & ~bus.i_stall;
      do_advance  = ~bus.i_redirect & ~bus.i_stall;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pc <= RESET_PC;
    end else if (do_redirect) begin
      // Targets are forced to a word boundary; misalignment is only reported.
      pc <= {bus.i_redirect_pc[ADDR_W-1:2], 2'b00};
    end else if (do_advance) begin
      pc <= pc_plus4;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bus.o_id_pc    <= '0;
      bus.o_id_pc4   <= '0;
      bus.o_id_inst  <= NOP_INST;
      bus.o_id_valid <= 1'b0;
    end else if (do_bubble) begin
      bus.o_id_pc    <= '0;
      bus.o_id_pc4   <= '0;
      bus.o_id_inst  <= NOP_INST;
      bus.o_id_valid <= 1'b0;
    end else if (do_load) begin
      bus.o_id_pc    <= pc;
      bus.o_id_pc4   <= pc_plus4;
      bus.o_id_inst  <= bus.i_imem_inst;
      bus.o_id_valid <= 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bus.o_misalign  <= 1'b0;
      bus.o_fetch_cnt <= '0;
    end else begin
      bus.o_misalign <= do_redirect & (|bus.i_redirect_pc[1:0]);
      if (do_load) bus.o_fetch_cnt <= bus.o_fetch_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios followed by random control traffic.
// Every cycle is compared against an abstract per-edge model of the IF stage.
module tb_fetch_stage;

  localparam int ADDR_W = 32;

  logic i_clk = 1'b0;
  logic i_rst_n;
  int   total = 0;
  int   bad   = 0;

  fetch_if #(.ADDR_W(ADDR_W)) bus ();

  fetch_stage #(.ADDR_W(ADDR_W)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return 32'h1000_0000 + (addr / 4);
  endfunction

  assign bus.i_imem_inst = mem_word(bus.o_imem_addr);

  // Reference state
  bit          m_boot;
  logic [31:0] m_pc, m_id_pc, m_id_pc4, m_id_inst, m_cnt;
  bit          m_valid, m_mis;

  task automatic model_reset();
    m_boot = 1; m_pc = 0; m_id_pc = 0; m_id_pc4 = 0;
    m_id_inst = 32'h13; m_valid = 0; m_mis = 0; m_cnt = 0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".addr"},  bus.o_imem_addr,         m_pc);
    check({tag, ".pc"},    bus.o_id_pc,             m_id_pc);
    check({tag, ".pc4"},   bus.o_id_pc4,            m_id_pc4);
    check({tag, ".inst"},  bus.o_id_inst,           m_id_inst);
    check({tag, ".valid"}, {31'd0, bus.o_id_valid}, {31'd0, m_valid});
    check({tag, ".mis"},   {31'd0, bus.o_misalign}, {31'd0, m_mis});
    check({tag, ".cnt"},   bus.o_fetch_cnt,         m_cnt);
  endtask

  // One rising edge: the model applies the rules to the current inputs, then DUT is sampled 1ns later.
  task automatic tick(input string tag);
    logic [31:0] fetched;
    fetched = mem_word(m_pc);
    if (m_boot) begin
      m_boot = 0;
      m_mis  = 0;
    end else begin
      m_mis = bus.i_redirect && (bus.i_redirect_pc % 4 != 0);
      if (bus.i_redirect || bus.i_flush) begin
        m_id_pc = 0; m_id_pc4 = 0; m_id_inst = 32'h13; m_valid = 0;
      end else if (!bus.i_stall) begin
        m_id_pc = m_pc; m_id_pc4 = m_pc + 4; m_id_inst = fetched;
        m_valid = 1; m_cnt = m_cnt + 1;
      end
      if (bus.i_redirect)    m_pc = bus.i_redirect_pc - (bus.i_redirect_pc % 4);
      else if (!bus.i_stall) m_pc = m_pc + 4;
    end
    @(posedge i_clk);
    #1;
    check_all(tag);
  endtask

  task automatic set_ctl(input bit stall, input bit flush, input bit redir, input logic [31:0] rpc);
    bus.i_stall = stall; bus.i_flush = flush;
    bus.i_redirect = redir; bus.i_redirect_pc = rpc;
  endtask

  initial begin
    i_rst_n = 1'b0;
    set_ctl(0, 0, 0, 32'h0);
    model_reset();
    repeat (2) @(posedge i_clk);
    #1;
    check_all("reset");

    // Control inputs during BOOT must be ignored
    set_ctl(1, 1, 1, 32'h0000_0200);
    i_rst_n = 1'b1;
    tick("boot");
    set_ctl(0, 0, 0, 32'h0);

    // Sequential fetch from RESET_PC
    for (int i = 0; i < 3; i++) tick("seq");
    check("t1.pc2",   bus.o_id_pc,   32'h8);
    check("t1.inst2", bus.o_id_inst, 32'h1000_0002);
    check("t1.cnt",   bus.o_fetch_cnt, 32'd3);
    tick("seq");
    check("t2.addr0", bus.o_imem_addr, 32'h10);

    // Three-cycle stall at PC=0x10
    set_ctl(1, 0, 0, 32'h0);
    for (int i = 0; i < 3; i++) tick("stall");
    check("t2.addr", bus.o_imem_addr, 32'h10);
    set_ctl(0, 0, 0, 32'h0);
    tick("unstall");
    check("t2.pc", bus.o_id_pc, 32'h10);

    // Redirect during stall
    set_ctl(1, 0, 1, 32'h100);
    tick("redir_stall");
    check("t3.addr",  bus.o_imem_addr, 32'h100);
    check("t3.inst",  bus.o_id_inst,   32'h13);
    set_ctl(0, 0, 0, 32'h0);
    tick("after_redir");
    check("t3.pc",  bus.o_id_pc,  32'h100);
    check("t3.pc4", bus.o_id_pc4, 32'h104);

    // Flush alone: bubble, PC keeps advancing
    set_ctl(0, 1, 0, 32'h0);
    tick("flush");
    set_ctl(1, 1, 0, 32'h0);
    tick("flush_stall");
    set_ctl(0, 0, 0, 32'h0);
    tick("post_flush");

    // Misaligned redirect target
    set_ctl(0, 0, 1, 32'h102);
    tick("mis");
    check("t4.addr", bus.o_imem_addr, 32'h100);
    check("t4.mis",  {31'd0, bus.o_misalign}, 32'd1);
    set_ctl(0, 0, 0, 32'h0);
    tick("mis_clear");
    check("t4.mis0", {31'd0, bus.o_misalign}, 32'd0);

    // PC wrap at the top of the address space
    set_ctl(0, 0, 1, 32'hFFFF_FFFC);
    tick("wrap_redir");
    set_ctl(0, 0, 0, 32'h0);
    tick("wrap_load");
    check("t5.pc",   bus.o_id_pc,     32'hFFFF_FFFC);
    check("t5.pc4",  bus.o_id_pc4,    32'h0);
    check("t5.addr", bus.o_imem_addr, 32'h0);
    tick("wrap_next");

    // Asynchronous reset between edges
    #2;
    i_rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(posedge i_clk);
    #1;
    check_all("rst_hold");
    i_rst_n = 1'b1;
    tick("reboot");
    tick("refetch0");
    check("t6.valid", {31'd0, bus.o_id_valid}, 32'd1);
    check("t6.pc",    bus.o_id_pc, 32'h0);
    tick("refetch1");

    // Random control traffic
    for (int i = 0; i < 400; i++) begin
      logic [31:0] rpc;
      if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      else                           rpc = $urandom;
      set_ctl($urandom_range(0, 9) < 3, $urandom_range(0, 9) < 2,
              $urandom_range(0, 9) == 0, rpc);
      tick("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
